// File: rtl/lcd_ctl.sv
// lcd_ctl -- timing engine for an HD44780-compatible character LCD.
//
// Firmware writes a 32-bit control word and toggles the strobe bit once per
// byte. Each toggle queues {RS, DATA} in a small FIFO. An FSM then drains the
// FIFO and produces the setup / enable-pulse / hold / execution-wait
// sequence on the LCD pins.
//
// Ports:
//   clk_i       core clock
//   rst_i       synchronous, active-high reset
//   lcd_word_i  control word: [31]=ON, [10]=strobe (toggle), [9]=RS, [7:0]=DATA
//   lcd_data_o  LCD D7..D0
//   lcd_rs_o    register select
//   lcd_rw_o    read/write, always 0 (write only)
//   lcd_en_o    enable strobe
//   lcd_on_o    panel power/backlight, registered copy of word bit 31
//   busy_o      FIFO non-empty or transfer in progress
//   ovf_o       sticky: a request was dropped because the FIFO was full
module lcd_ctl #(
    parameter int T_SETUP     = 2,
    parameter int T_PULSE     = 12,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 82000,
    parameter int DEPTH       = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] lcd_word_i,
    output logic [7:0]  lcd_data_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic        lcd_en_o,
    output logic        lcd_on_o,
    output logic        busy_o,
    output logic        ovf_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int MAX_A = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int MAX_B = (T_HOLD > T_EXEC) ? T_HOLD : T_EXEC;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_T = (MAX_C > T_EXEC_LONG) ? MAX_C : T_EXEC_LONG;
    // At least 17 bits so the default long execution wait fits.
    localparam int CNT_W = ($clog2(MAX_T) > 17) ? $clog2(MAX_T) : 17;

    localparam logic [CNT_W-1:0] CNT_ONE     = 1;
    localparam logic [CNT_W-1:0] LD_SETUP    = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_PULSE    = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] LD_HOLD     = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_EXEC     = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] LD_EXEC_LNG = CNT_W'(T_EXEC_LONG - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        EXEC
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic             strb_q;
    logic             req;
    logic [8:0]       mem [DEPTH];
    logic [8:0]       head;
    logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic             full, empty, push, pop;

    logic             rs_q;
    logic [7:0]       data_q;
    logic             en_q, on_q, busy_q, ovf_q;
    logic             long_cmd;

    // Bits of the control word this block does not look at.
    logic             unused_bits;
    assign unused_bits = ^{lcd_word_i[30:11], lcd_word_i[8]};

    // Every level change of the strobe bit is one request.
    assign req   = lcd_word_i[10] ^ strb_q;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // still accepted then.
    assign push  = req && (!full || pop);
    assign head  = mem[rd_ptr[AW-1:0]];

    assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
    assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};

    // Clear display and return home need the long execution wait.
    assign long_cmd = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02) || (data_q == 8'h03));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    cnt_nxt   = LD_SETUP;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    cnt_nxt   = LD_PULSE;
                    state_nxt = PULSE;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    cnt_nxt   = LD_HOLD;
                    state_nxt = HOLD;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    cnt_nxt   = long_cmd ? LD_EXEC_LNG : LD_EXEC;
                    state_nxt = EXEC;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FIFO storage carries no reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {lcd_word_i[9], lcd_word_i[7:0]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            strb_q <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            state  <= IDLE;
            cnt    <= '0;
            rs_q   <= 1'b0;
            data_q <= 8'h00;
            en_q   <= 1'b0;
            on_q   <= 1'b0;
            busy_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            strb_q <= lcd_word_i[10];
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            if (pop) begin
                rs_q   <= head[8];
                data_q <= head[7:0];
            end
            // Outputs are registered from next-state values so they line
            // up with the state they describe.
            en_q   <= (state_nxt == PULSE);
            on_q   <= lcd_word_i[31];
            busy_q <= (state_nxt != IDLE) || (wr_ptr_nxt != rd_ptr_nxt);
            if (req && !push) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign lcd_data_o = data_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_rw_o   = 1'b0;
    assign lcd_en_o   = en_q;
    assign lcd_on_o   = on_q;
    assign busy_o     = busy_q;
    assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_lcd_ctl.sv
// Testbench for lcd_ctl. Stimulus queues the expected transfer for every
// request it issues; a monitor watching the LCD pins pops and checks each
// enable pulse (RS/DATA, pulse width, gap to the next pulse or to idle).
module tb_lcd_ctl;

    localparam int T_SETUP     = 2;
    localparam int T_PULSE     = 4;
    localparam int T_HOLD      = 1;
    localparam int T_EXEC      = 5;
    localparam int T_EXEC_LONG = 20;
    localparam int DEPTH       = 4;

    // Cycles from the first EN-low cycle to:
    //   busy low after a short command: HOLD 1 + EXEC 5           = 6
    //   busy low after a long command:  HOLD 1 + EXEC 20          = 21
    //   next EN rise (queued entry):    HOLD 1 + EXEC 5 + IDLE 1 + SETUP 2 = 9
    localparam int TAIL_SHORT = 6;
    localparam int TAIL_LONG  = 21;
    localparam int TAIL_NEXT  = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        on_b = 1'b0;
    logic        strb = 1'b0;
    logic        rs_b = 1'b0;
    logic [7:0]  data_b = 8'h00;
    logic [31:0] lcd_word;
    logic [7:0]  lcd_data;
    logic        lcd_rs, lcd_rw, lcd_en, lcd_on, busy, ovf;

    // Ignored bits carry a fixed junk pattern.
    assign lcd_word = {on_b, 20'h5A5A5, strb, rs_b, 1'b1, data_b};

    lcd_ctl #(
        .T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_HOLD(T_HOLD),
        .T_EXEC(T_EXEC), .T_EXEC_LONG(T_EXEC_LONG), .DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst), .lcd_word_i(lcd_word),
        .lcd_data_o(lcd_data), .lcd_rs_o(lcd_rs), .lcd_rw_o(lcd_rw),
        .lcd_en_o(lcd_en), .lcd_on_o(lcd_on), .busy_o(busy), .ovf_o(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         width;
        int         tail;
    } item_t;

    item_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    bit    mon_on  = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: samples on the falling edge.
    initial begin
        logic  prev_en;
        bit    in_tail;
        bit    have_cur;
        int    start_c;
        int    fall_c;
        item_t cur;
        prev_en  = 1'b0;
        in_tail  = 1'b0;
        have_cur = 1'b0;
        start_c  = 0;
        fall_c   = 0;
        forever begin
            @(negedge clk);
            if (!mon_on) begin
                prev_en  = 1'b0;
                in_tail  = 1'b0;
                have_cur = 1'b0;
            end else begin
                if (in_tail && !lcd_en && !busy) begin
                    chk("tail_to_idle", cyc - fall_c, cur.tail);
                    in_tail = 1'b0;
                end
                if (lcd_en && !prev_en) begin
                    if (in_tail) begin
                        chk("tail_to_next", cyc - fall_c, cur.tail);
                        in_tail = 1'b0;
                    end
                    chk("pulse_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        cur      = exp_q.pop_front();
                        have_cur = 1'b1;
                        chk("pulse_rs", lcd_rs, cur.rs);
                        chk("pulse_data", lcd_data, cur.data);
                    end else begin
                        have_cur = 1'b0;
                    end
                    start_c = cyc;
                end else if (lcd_en && have_cur) begin
                    chk("stable_rs", lcd_rs, cur.rs);
                    chk("stable_data", lcd_data, cur.data);
                end
                if (!lcd_en && prev_en) begin
                    if (have_cur) begin
                        chk("pulse_width", cyc - start_c, cur.width);
                        chk("hold_data", lcd_data, cur.data);
                    end
                    fall_c  = cyc;
                    in_tail = have_cur;
                end
                prev_en = lcd_en;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic rs, input logic [7:0] d, input bit queued, input int tail);
        item_t it;
        rs_b   = rs;
        data_b = d;
        strb   = ~strb;
        if (queued) begin
            it.rs    = rs;
            it.data  = d;
            it.width = T_PULSE;
            it.tail  = tail;
            exp_q.push_back(it);
        end
        tick();
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (busy && n < max_cyc) begin
            tick();
            n++;
        end
        chk("idle_timeout", busy, 0);
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        strb   = 1'b0;
        on_b   = 1'b0;
        rs_b   = 1'b0;
        data_b = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_hi;
        int busy_hi;
        logic [7:0] d;

        do_reset();
        chk("rst_en", lcd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_on", lcd_on, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_data", lcd_data, 0);
        chk("rst_rw", lcd_rw, 0);
        mon_on = 1'b1;

        // Single data byte, cycle-exact view; toggle issued in cycle 0.
        rs_b   = 1'b1;
        data_b = 8'h41;
        strb   = ~strb;
        begin
            item_t it;
            it.rs = 1'b1; it.data = 8'h41; it.width = T_PULSE; it.tail = TAIL_SHORT;
            exp_q.push_back(it);
        end
        for (int c = 0; c <= 15; c++) begin
            chk($sformatf("t1_en_c%0d", c), lcd_en, int'(c >= 4 && c <= 7));
            chk($sformatf("t1_busy_c%0d", c), busy, int'(c >= 1 && c <= 13));
            chk($sformatf("t1_rw_c%0d", c), lcd_rw, 0);
            if (c >= 2 && c <= 8) begin
                chk($sformatf("t1_rs_c%0d", c), lcd_rs, 1);
                chk($sformatf("t1_data_c%0d", c), lcd_data, 8'h41);
            end
            tick();
        end
        wait_idle(10);

        // Long vs normal execution waits.
        send(1'b0, 8'h01, 1'b1, TAIL_LONG);  wait_idle(100);
        send(1'b0, 8'h38, 1'b1, TAIL_SHORT); wait_idle(100);
        send(1'b1, 8'h01, 1'b1, TAIL_SHORT); wait_idle(100);
        send(1'b0, 8'h02, 1'b1, TAIL_LONG);  wait_idle(100);
        send(1'b0, 8'h03, 1'b1, TAIL_LONG);  wait_idle(100);
        send(1'b0, 8'h04, 1'b1, TAIL_SHORT); wait_idle(100);

        // Burst of four consecutive toggles.
        for (int i = 0; i < 4; i++) begin
            d = 8'h10 + 8'(i);
            send(1'b0, d, 1'b1, (i == 3) ? TAIL_SHORT : TAIL_NEXT);
        end
        wait_idle(200);
        chk("burst_ovf", ovf, 0);

        // Overflow: six consecutive toggles, the sixth is dropped.
        for (int i = 0; i < 6; i++) begin
            d = 8'h20 + 8'(i);
            send(1'b1, d, i < 5, (i < 4) ? TAIL_NEXT : TAIL_SHORT);
            if (i == 4) chk("ovf_before_drop", ovf, 0);
            if (i == 5) chk("ovf_after_drop", ovf, 1);
        end
        wait_idle(300);
        chk("ovf_sticky", ovf, 1);
        do_reset();
        chk("ovf_cleared", ovf, 0);

        // Reset during PULSE with two entries queued.
        mon_on = 1'b0;
        send(1'b1, 8'h55, 1'b0, 0);
        send(1'b1, 8'h66, 1'b0, 0);
        send(1'b1, 8'h77, 1'b0, 0);
        tick();
        chk("t5_en_c4", lcd_en, 1);
        tick();
        chk("t5_en_c5", lcd_en, 1);
        chk("t5_data_c5", lcd_data, 8'h55);
        rst    = 1'b1;
        strb   = 1'b0;
        rs_b   = 1'b0;
        data_b = 8'h00;
        tick();
        rst = 1'b0;
        chk("t5_en_after", lcd_en, 0);
        chk("t5_busy_after", busy, 0);
        chk("t5_data_after", lcd_data, 0);
        chk("t5_rs_after", lcd_rs, 0);
        en_hi   = 0;
        busy_hi = 0;
        for (int i = 0; i < 60; i++) begin
            if (lcd_en) en_hi++;
            if (busy) busy_hi++;
            tick();
        end
        chk("t5_no_pulses", en_hi, 0);
        chk("t5_no_busy", busy_hi, 0);
        mon_on = 1'b1;

        // ON bit follows bit 31 one cycle later and does not gate transfers.
        on_b = 1'b1;
        chk("on_same_cycle", lcd_on, 0);
        tick();
        chk("on_next_cycle", lcd_on, 1);
        en_hi   = 0;
        busy_hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (lcd_en) en_hi++;
            if (busy) busy_hi++;
            tick();
        end
        chk("on_no_en", en_hi, 0);
        chk("on_no_busy", busy_hi, 0);
        on_b = 1'b0;
        send(1'b0, 8'h0C, 1'b1, TAIL_SHORT);
        chk("on_off", lcd_on, 0);
        wait_idle(100);

        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
